// File: rtl/common_pkg.sv
// Shared memory-request types, arbiter state encoding and requester indices.
package common;

    typedef enum logic [1:0] {
        MEM_SIZE_BYTE = 2'd0,
        MEM_SIZE_HALF = 2'd1,
        MEM_SIZE_WORD = 2'd2
    } mem_req_size;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT  = 2'd1,
        DRAIN = 2'd2
    } mem_arb_state_e;

    localparam int unsigned MEM_REQ_HOST = 0;
    localparam int unsigned MEM_REQ_CPU  = 1;

    // Request fields captured at the grant cycle.
    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_req_t;

    // Number of byte beats for a size code; code 3 is rejected before use.
    function automatic logic [2:0] beats_of(input logic [1:0] size);
        case (size)
            2'd0:    beats_of = 3'd1;
            2'd1:    beats_of = 3'd2;
            default: beats_of = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_beat_seq.sv
// Beat sequencer for one latched request: beat counter, byte address,
// write-lane select and little-endian read-data assembly.
module mem_arb_beat_seq
    import common::*;
#(
    parameter int unsigned ADDR_BITS = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  mem_req_t             req,
    input  logic                 step,
    input  logic                 capture,
    input  logic [7:0]           mem_rdata,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [7:0]           mem_wdata,
    output logic                 write,
    output logic                 last,
    output logic [31:0]          rd_word
);

    mem_req_t    req_q;
    logic [1:0]  cnt_q;
    logic        cap_q;
    logic [1:0]  cap_idx_q;
    logic [31:0] buf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= '0;
            cnt_q     <= 2'd0;
            cap_q     <= 1'b0;
            cap_idx_q <= 2'd0;
            buf_q     <= 32'd0;
        end else begin
            cap_q     <= capture;
            cap_idx_q <= cnt_q;
            if (load) begin
                req_q <= req;
                cnt_q <= 2'd0;
                buf_q <= 32'd0;
            end else begin
                if (step) begin
                    cnt_q <= cnt_q + 2'd1;
                end
                if (cap_q) begin
                    buf_q[{cap_idx_q, 3'b000} +: 8] <= mem_rdata;
                end
            end
        end
    end

    // The byte returned this cycle is folded in so DRAIN can publish the full word.
    always_comb begin
        rd_word = buf_q;
        if (cap_q) begin
            rd_word[{cap_idx_q, 3'b000} +: 8] = mem_rdata;
        end
    end

    assign mem_addr  = ADDR_BITS'(req_q.addr + 32'(cnt_q));
    assign mem_wdata = req_q.data[{cnt_q, 3'b000} +: 8];
    assign write     = req_q.write;
    assign last      = ({1'b0, cnt_q} == (beats_of(req_q.size) - 3'd1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the byte-wide device memory (host = req 0, CPU = req 1).
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module mem_arbiter
    import common::*;
#(
    parameter int unsigned ADDR_BITS = 14,
    parameter int unsigned MEM_BYTES = 16384
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [1:0]            i_req_valid,
    input  logic [1:0]            i_req_write,
    input  logic [1:0][1:0]       i_req_size,
    input  logic [1:0][31:0]      i_req_addr,
    input  logic [1:0][31:0]      i_req_data,
    output logic [1:0]            o_req_ready,
    output logic [1:0]            o_rsp_valid,
    output logic [31:0]           o_rsp_data,
    output logic                  o_rsp_err,
    output logic                  o_busy,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [ADDR_BITS-1:0]  o_mem_addr,
    output logic [7:0]            o_mem_wdata,
    input  logic [7:0]            i_mem_rdata
);

    mem_arb_state_e state_q, state_d;
    logic           accept, pick1, load, err_c, gid_q, last, seq_write;
    logic [1:0]     rsp_valid_d;
    logic           rsp_err_d;
    logic [31:0]    rsp_data_d, rd_word;
    mem_req_t       req_c;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_q;

    // Last-granted requester loses a tie; reset value lets the host win first.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_q <= 1'b1;
        end else if (load) begin
            last_q <= pick1;
        end
    end

    assign pick1 = i_req_valid[1] && (!i_req_valid[0] || !last_q);
`else
    assign pick1 = i_req_valid[1] && !i_req_valid[0];
`endif

    assign accept      = (state_q == IDLE) && (|i_req_valid);
    assign o_req_ready = accept ? (pick1 ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        req_c.write = i_req_write[pick1];
        req_c.size  = i_req_size[pick1];
        req_c.addr  = i_req_addr[pick1];
        req_c.data  = i_req_data[pick1];
    end

    // Last byte must land below MEM_BYTES; 33-bit sum so the check cannot wrap.
    assign err_c = (req_c.size == 2'd3) ||
                   (({1'b0, req_c.addr} + 33'(beats_of(req_c.size)) - 33'd1) >= 33'(MEM_BYTES));

    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        rsp_valid_d = 2'b00;
        rsp_err_d   = 1'b0;
        rsp_data_d  = o_rsp_data;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    load = 1'b1;
                    if (err_c) begin
                        rsp_valid_d = pick1 ? 2'b10 : 2'b01;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = BEAT;
                    end
                end
            end
            BEAT: begin
                if (last) begin
                    if (seq_write) begin
                        state_d     = IDLE;
                        rsp_valid_d = gid_q ? 2'b10 : 2'b01;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d     = IDLE;
                rsp_valid_d = gid_q ? 2'b10 : 2'b01;
                rsp_data_d  = rd_word;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            gid_q       <= 1'b0;
            o_rsp_valid <= 2'b00;
            o_rsp_err   <= 1'b0;
            o_rsp_data  <= 32'd0;
        end else begin
            state_q     <= state_d;
            o_rsp_valid <= rsp_valid_d;
            o_rsp_err   <= rsp_err_d;
            o_rsp_data  <= rsp_data_d;
            if (load) begin
                gid_q <= pick1;
            end
        end
    end

    assign o_busy   = (state_q != IDLE);
    assign o_mem_en = (state_q == BEAT);
    assign o_mem_we = (state_q == BEAT) && seq_write;

    mem_arb_beat_seq #(
        .ADDR_BITS (ADDR_BITS)
    ) u_beat_seq (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .load      (load),
        .req       (req_c),
        .step      (o_mem_en),
        .capture   (o_mem_en && !o_mem_we),
        .mem_rdata (i_mem_rdata),
        .mem_addr  (o_mem_addr),
        .mem_wdata (o_mem_wdata),
        .write     (seq_write),
        .last      (last),
        .rd_word   (rd_word)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-array memory model.
module tb_mem_arbiter;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_write;
    logic [1:0][1:0]  req_size;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_data;
    logic [1:0]       req_ready;
    logic [1:0]       rsp_valid;
    logic [31:0]      rsp_data;
    logic             rsp_err;
    logic             busy;
    logic             mem_en;
    logic             mem_we;
    logic [13:0]      mem_addr;
    logic [7:0]       mem_wdata;
    logic [7:0]       mem_rdata;

    logic [7:0] mem [0:16383];
    int checks = 0;
    int errors = 0;

    mem_arbiter dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_write (req_write),
        .i_req_size  (req_size),
        .i_req_addr  (req_addr),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .o_rsp_valid (rsp_valid),
        .o_rsp_data  (rsp_data),
        .o_rsp_err   (rsp_err),
        .o_busy      (busy),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic w, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] d);
        req_valid[r] = v;
        req_write[r] = w;
        req_size[r]  = sz;
        req_addr[r]  = a;
        req_data[r]  = d;
        #1;
    endtask

    logic [1:0] rr_exp [0:3];

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        mem_rdata = 8'h00;
        rst_n = 1'b0;
        req_valid = '0; req_write = '0; req_size = '0; req_addr = '0; req_data = '0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // 1: host word write then word read
        set_req(0, 1'b1, 1'b1, 2'd2, 32'h10, 32'h11223344);
        chk("t1_ready", 32'(req_ready), 32'd1);
        tick();
        set_req(0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        chk("t1_b0_en", 32'({mem_en, mem_we}), 32'd3);
        chk("t1_b0_addr", 32'(mem_addr), 32'h10);
        chk("t1_b0_wdata", 32'(mem_wdata), 32'h44);
        tick();
        chk("t1_b1_addr", 32'(mem_addr), 32'h11);
        chk("t1_b1_wdata", 32'(mem_wdata), 32'h33);
        tick(); tick();
        chk("t1_b3_wdata", 32'(mem_wdata), 32'h11);
        tick();
        chk("t1_wr_rsp", 32'({rsp_valid, rsp_err, busy}), 32'b0100);
        chk("t1_mem", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'h11223344);
        set_req(0, 1'b1, 1'b0, 2'd2, 32'h10, 32'h0);
        chk("t1_rd_ready", 32'(req_ready), 32'd1);
        tick();
        set_req(0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        chk("t1_rd_we", 32'({mem_en, mem_we}), 32'd2);
        repeat (4) tick();
        chk("t1_drain", 32'({rsp_valid, busy, mem_en}), 32'b0010);
        tick();
        chk("t1_rd_rsp", 32'({rsp_valid, rsp_err}), 32'b010);
        chk("t1_rd_data", rsp_data, 32'h11223344);

        // 2: CPU half read at the top of memory, then out of range
        mem[14'h3FFE] = 8'hAA;
        mem[14'h3FFF] = 8'hBB;
        set_req(1, 1'b1, 1'b0, 2'd1, 32'h3FFE, 32'h0);
        chk("t2_ready", 32'(req_ready), 32'd2);
        tick();
        set_req(1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        tick();
        chk("t2_b1_addr", 32'(mem_addr), 32'h3FFF);
        tick(); tick();
        chk("t2_rsp", 32'({rsp_valid, rsp_err}), 32'b100);
        chk("t2_data", rsp_data, 32'h0000BBAA);
        set_req(1, 1'b1, 1'b0, 2'd1, 32'h3FFF, 32'h0);
        chk("t2e_ready", 32'(req_ready), 32'd2);
        tick();
        set_req(1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        chk("t2e_rsp", 32'({rsp_valid, rsp_err, mem_en, busy}), 32'b10100);
        tick();
        chk("t2e_after", 32'({rsp_valid, mem_en, busy}), 32'd0);

        // 3: simultaneous requests, fixed priority; CPU granted in host response cycle
        set_req(0, 1'b1, 1'b1, 2'd0, 32'h20, 32'h5A);
        set_req(1, 1'b1, 1'b1, 2'd0, 32'h21, 32'hC3);
        chk("t3_ready0", 32'(req_ready), 32'd1);
        tick();
        set_req(0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        chk("t3_beat_ready", 32'(req_ready), 32'd0);
        chk("t3_beat_addr", 32'(mem_addr), 32'h20);
        tick();
        chk("t3_host_rsp", 32'(rsp_valid), 32'd1);
        chk("t3_ready1", 32'(req_ready), 32'd2);
        tick();
        set_req(1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        chk("t3_cpu_beat", {16'h0, 2'b0, mem_addr}, 32'h21);
        chk("t3_cpu_wdata", 32'(mem_wdata), 32'hC3);
        tick();
        chk("t3_cpu_rsp", 32'(rsp_valid), 32'd2);
        chk("t3_mem", {16'h0, mem[8'h21], mem[8'h20]}, 32'h0000C35A);

        // 3b: both held valid over four grants
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr_exp[0] = 2'd1; rr_exp[1] = 2'd2; rr_exp[2] = 2'd1; rr_exp[3] = 2'd2;
`else
        rr_exp[0] = 2'd1; rr_exp[1] = 2'd1; rr_exp[2] = 2'd1; rr_exp[3] = 2'd1;
`endif
        set_req(0, 1'b1, 1'b1, 2'd0, 32'h30, 32'h01);
        set_req(1, 1'b1, 1'b1, 2'd0, 32'h31, 32'h02);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3b_grant%0d", i), 32'(req_ready), 32'(rr_exp[i]));
            tick(); tick();
        end
        set_req(0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        tick();

        // 4: size code 3 from CPU
        set_req(1, 1'b1, 1'b0, 2'd3, 32'h0, 32'h0);
        chk("t4_ready", 32'(req_ready), 32'd2);
        tick();
        set_req(1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        chk("t4_rsp", 32'({rsp_valid, rsp_err, mem_en, busy}), 32'b10100);

        // 5: reset during beat 2 of a word write
        tick();
        set_req(0, 1'b1, 1'b1, 2'd2, 32'h40, 32'hDDCCBBAA);
        chk("t5_ready", 32'(req_ready), 32'd1);
        tick();
        set_req(0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        tick(); tick();
        chk("t5_b2_addr", 32'({mem_en, mem_addr}), 32'h4042);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_outs", 32'({req_ready, rsp_valid, rsp_err, busy, mem_en, mem_we}), 32'd0);
        chk("t5_rst_data", rsp_data, 32'd0);
        tick(); tick();
        chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("t5_mem", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'h0000BBAA);
        set_req(0, 1'b1, 1'b1, 2'd0, 32'h44, 32'h77);
        chk("t5_next_ready", 32'(req_ready), 32'd1);
        tick();
        set_req(0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        tick();
        chk("t5_next_rsp", 32'(rsp_valid), 32'd1);
        chk("t5_next_mem", 32'(mem[8'h44]), 32'h77);

        // 6: back-to-back CPU byte writes with valid held
        set_req(1, 1'b1, 1'b1, 2'd0, 32'h50, 32'h01);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t6_accept%0d", i), 32'({req_ready, busy}), 32'b100);
            tick();
            chk($sformatf("t6_beat%0d", i), 32'({req_ready, busy, 2'b0, mem_addr}), 32'h10000 | 32'(32'h50 + 32'(i)));
            set_req(1, 1'b1, 1'b1, 2'd0, 32'(32'h51 + 32'(i)), 32'(i + 2));
            tick();
        end
        set_req(1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        chk("t6_mem", {mem[8'h53], mem[8'h52], mem[8'h51], mem[8'h50]}, 32'h04030201);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
